axi_xbar_age_arbiter: RTL and testbench

//  Arbiter for one AXI crossbar output port, shared between NUM_REQ input-side requesters.

---
 rtl/axi_xbar_arb_pkg.sv | 23 ++
 rtl/axi_xbar_maxsel.sv | 44 ++++
 rtl/axi_xbar_age_arbiter.sv | 122 ++++++++++++
 tb/tb_axi_xbar_age_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_arb_pkg.sv
// Shared types and helpers for the AXI crossbar output-port age/QoS arbiter.
// Default widths live here so the top and its sub-blocks agree.
package axi_xbar_arb_pkg;

    localparam int unsigned ARB_NUM_REQ = 8;
    localparam int unsigned ARB_IDX_W   = 3;
    localparam int unsigned ARB_QOS_W   = 4;
    localparam int unsigned ARB_AGE_W   = 4;
    localparam int unsigned KEY_W       = 1 + ARB_QOS_W + ARB_AGE_W;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    function automatic logic [ARB_NUM_REQ-1:0] onehot(input logic [ARB_IDX_W-1:0] idx);
        logic [ARB_NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/axi_xbar_maxsel.sv
// Combinational balanced max-select tree: returns the largest key and its index.
// Equal keys resolve toward the lower index at every node.
module axi_xbar_maxsel #(
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned KEY_W  = 9,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [NUM_IN*KEY_W-1:0] keys_i,
    output logic [KEY_W-1:0]        max_key_o,
    output logic [IDX_W-1:0]        max_idx_o
);

    localparam int unsigned Leaves = 1 << IDX_W;
    localparam int unsigned Nodes  = 2 * Leaves - 1;

    // Heap layout: node n has children 2n+1 (left, lower index) and 2n+2 (right).
    logic [KEY_W-1:0] node_key [Nodes];
    logic [IDX_W-1:0] node_idx [Nodes];

    always_comb begin
        for (int i = 0; i < Leaves; i++) begin
            if (i < NUM_IN) begin
                node_key[Leaves-1+i] = keys_i[i*KEY_W +: KEY_W];
                node_idx[Leaves-1+i] = IDX_W'(i);
            end else begin
                node_key[Leaves-1+i] = '0;
                node_idx[Leaves-1+i] = IDX_W'(NUM_IN - 1);
            end
        end
        for (int n = Leaves - 2; n >= 0; n--) begin
            if (node_key[2*n+2] > node_key[2*n+1]) begin
                node_key[n] = node_key[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end else begin
                node_key[n] = node_key[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end
        end
    end

    assign max_key_o = node_key[0];
    assign max_idx_o = node_idx[0];

endmodule

// File: rtl/axi_xbar_age_arbiter.sv
// Output-port arbiter: strict QoS, then oldest request wins; the grant is registered
// and held until the owning transaction acks.
module axi_xbar_age_arbiter
    import axi_xbar_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned IDX_W   = ARB_IDX_W,
    parameter int unsigned QOS_W   = ARB_QOS_W,
    parameter int unsigned AGE_W   = ARB_AGE_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*QOS_W-1:0] qos_i,
    input  logic                     ack_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     grant_valid_o,
    output logic [IDX_W-1:0]         grant_index_o
);

    localparam int unsigned KeyW = 1 + QOS_W + AGE_W;
    localparam logic [AGE_W-1:0] AgeMax = '1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               valid_q, valid_d;
    logic [AGE_W-1:0]   age_q [NUM_REQ];
    logic [AGE_W-1:0]   age_d [NUM_REQ];

    logic [NUM_REQ*KeyW-1:0] keys;
    logic [KeyW-1:0]         win_key;
    logic [IDX_W-1:0]        win_idx;
    logic                    launch;
    logic                    unused_key_bits;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            keys[i*KeyW +: KeyW] = {req_i[i], qos_i[i*QOS_W +: QOS_W], age_q[i]};
        end
    end

    axi_xbar_maxsel #(
        .NUM_IN (NUM_REQ),
        .KEY_W  (KeyW),
        .IDX_W  (IDX_W)
    ) u_maxsel (
        .keys_i    (keys),
        .max_key_o (win_key),
        .max_idx_o (win_idx)
    );

    // Only the key MSB matters here: it is set iff some requester is active.
    assign unused_key_bits = ^win_key[KeyW-2:0];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        valid_d = valid_q;
        launch  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_key[KeyW-1]) begin
                    launch  = 1'b1;
                    grant_d = onehot(win_idx);
                    index_d = win_idx;
                    valid_d = 1'b1;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (ack_i) begin
                    grant_d = '0;
                    index_d = '0;
                    valid_d = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // The owner's age stays cleared for the whole tenure, including the ack edge.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_i[i] || (launch && win_idx == IDX_W'(i)) ||
                (state_q == ARB_BUSY && grant_q[i])) begin
                age_d[i] = '0;
            end else if (age_q[i] != AgeMax) begin
                age_d[i] = age_q[i] + 1'b1;
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            valid_q <= valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = valid_q;
    assign grant_index_o = index_q;

endmodule

// File: tb/tb_axi_xbar_age_arbiter.sv
// Bench for axi_xbar_age_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_axi_xbar_age_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [31:0] qos;
    logic        ack;
    logic [7:0]  grant;
    logic        grant_valid;
    logic [2:0]  grant_index;

    int n_vec = 0;
    int n_err = 0;

    // Model state: is a grant outstanding, who owns it, and how long each requester waited.
    bit m_busy;
    int m_gidx;
    int m_age [8];

    axi_xbar_age_arbiter u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .qos_i         (qos),
        .ack_i         (ack),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_index_o (grant_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Highest QoS wins, then highest age; a strictly larger score is needed to displace
    // an earlier (lower-index) candidate.
    function automatic int winner(input logic [7:0] rq, input logic [31:0] q);
        int best  = -1;
        int score = -1;
        for (int i = 0; i < 8; i++) begin
            if (rq[i]) begin
                int s = int'(q[i*4 +: 4]) * 16 + m_age[i];
                if (s > score) begin
                    score = s;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_edge(input bit r, input logic [7:0] rq, input logic [31:0] q,
                              input bit a);
        int w;
        if (r) begin
            m_busy = 1'b0;
            m_gidx = 0;
            for (int i = 0; i < 8; i++) m_age[i] = 0;
        end else begin
            w = winner(rq, q);
            for (int i = 0; i < 8; i++) begin
                if (!rq[i]) m_age[i] = 0;
                else if ((!m_busy && i == w) || (m_busy && i == m_gidx)) m_age[i] = 0;
                else if (m_age[i] < 15) m_age[i] = m_age[i] + 1;
            end
            if (!m_busy && rq != 8'h00) begin
                m_busy = 1'b1;
                m_gidx = w;
            end else if (m_busy && a) begin
                m_busy = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit r, input logic [7:0] rq, input logic [31:0] q, input bit a);
        logic [7:0] exp_grant;
        rst = r;
        req = rq;
        qos = q;
        ack = a;
        @(posedge clk);
        model_edge(r, rq, q, a);
        #1;
        exp_grant = m_busy ? (8'h01 << m_gidx) : 8'h00;
        chk("grant", {24'h0, grant}, {24'h0, exp_grant});
        chk("grant_valid", {31'h0, grant_valid}, {31'h0, m_busy});
        chk("grant_index", {29'h0, grant_index}, m_busy ? m_gidx : 0);
        chk("onehot0", {31'h0, $onehot0(grant)}, 32'h1);
    endtask

    initial begin
        logic [7:0]  rq;
        logic [31:0] q;
        bit          a;
        bit          r;

        rst = 1'b1;
        req = '0;
        qos = '0;
        ack = 1'b0;
        m_busy = 1'b0;
        m_gidx = 0;
        for (int i = 0; i < 8; i++) m_age[i] = 0;

        // Reset held with every requester active.
        step(1, 8'hFF, 0, 0);
        chk("rst_grant_a", {24'h0, grant}, 32'h0);
        step(1, 8'hFF, 0, 0);
        chk("rst_grant_b", {24'h0, grant}, 32'h0);
        chk("rst_valid", {31'h0, grant_valid}, 32'h0);
        chk("rst_index", {29'h0, grant_index}, 32'h0);
        step(0, 8'hFF, 0, 0);
        chk("rst_first_grant", {24'h0, grant}, 32'h01);
        step(0, 8'hFF, 0, 1);
        step(1, 8'h00, 0, 0);

        // Basic: tie at age 0 goes to index 1; index 2 ages meanwhile.
        step(0, 8'h06, 0, 0);
        chk("basic_g1", {24'h0, grant}, 32'h02);
        chk("basic_i1", {29'h0, grant_index}, 32'd1);
        repeat (3) step(0, 8'h06, 0, 0);
        step(0, 8'h06, 0, 1);
        chk("basic_ack_clear", {24'h0, grant}, 32'h00);
        step(0, 8'h06, 0, 0);
        chk("basic_g2", {24'h0, grant}, 32'h04);
        chk("basic_i2", {29'h0, grant_index}, 32'd2);
        step(0, 8'h06, 0, 1);
        step(1, 8'h00, 0, 0);

        // QoS beats index order; the loser is served after the ack.
        step(0, 8'h21, 32'h0030_0001, 0);
        chk("qos_win", {29'h0, grant_index}, 32'd5);
        repeat (2) step(0, 8'h21, 32'h0030_0001, 0);
        step(0, 8'h21, 32'h0030_0001, 1);
        chk("qos_ack", {31'h0, grant_valid}, 32'h0);
        step(0, 8'h01, 32'h0030_0001, 0);
        chk("qos_next", {24'h0, grant}, 32'h01);
        step(0, 8'h01, 32'h0030_0001, 1);
        step(1, 8'h00, 0, 0);

        // Saturation: req3 waits 3 cycles longer than req1; wrapping ages would favour 3.
        step(0, 8'h80, 0, 0);
        chk("sat_g7", {24'h0, grant}, 32'h80);
        repeat (3) step(0, 8'h88, 0, 0);
        repeat (20) step(0, 8'h8A, 0, 0);
        chk("sat_hold", {24'h0, grant}, 32'h80);
        step(0, 8'h8A, 0, 1);
        step(0, 8'h0A, 0, 0);
        chk("sat_tie_low", {24'h0, grant}, 32'h02);

        // Req/qos churn while busy must not move the grant.
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h02 | 8'($urandom), $urandom, 0);
            chk("proto_hold", {24'h0, grant}, 32'h02);
        end

        // Mid-transaction reset, then a stray ack in idle.
        step(1, 8'h0A, 0, 0);
        chk("midrst_grant", {24'h0, grant}, 32'h0);
        chk("midrst_valid", {31'h0, grant_valid}, 32'h0);
        step(0, 8'h00, 0, 1);
        chk("stray_ack", {24'h0, grant}, 32'h0);
        step(0, 8'h00, 0, 0);
        chk("stray_ack_idle", {31'h0, grant_valid}, 32'h0);

        // Randomized traffic; the owner keeps its request up until ack.
        for (int k = 0; k < 3000; k++) begin
            rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if (m_busy) rq = rq | (8'h01 << m_gidx);
            q = $urandom;
            a = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(r, rq, q, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
